// File: rtl/sha256_w_sched_ctrl.sv
// SHA-256 message-schedule sequencer: loads a 512-bit block into a 16-word sliding
// window and streams W[0..63] under valid/ready, expanding one word per transfer.
module sha256_w_sched_ctrl (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic         abort,
  input  logic [511:0] block_in,
  input  logic         w_ready,
  output logic         w_valid,
  output logic [31:0]  w_out,
  output logic [5:0]   w_index,
  output logic         busy,
  output logic         done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nxt;
  logic [31:0] win [16];
  logic [5:0]  idx;
  logic        xfer, load, last;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    rotr = (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    sig0 = rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    sig1 = rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  assign xfer = (state == RUN) && w_ready;
  assign load = (state == IDLE) && start && !abort;
  assign last = xfer && (idx == 6'd63);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (load) state_nxt = RUN;
      RUN:  if (abort || last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    w_valid = 1'b0;
    if (state == RUN) begin
      busy    = 1'b1;
      w_valid = 1'b1;
    end
  end

  // Window slides on every accepted word; win[15] receives W[t+16] from the recurrence.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < 16; i++) win[i] <= block_in[511 - 32*i -: 32];
    end else if (xfer) begin
      for (int i = 0; i < 15; i++) win[i] <= win[i+1];
      win[15] <= sig1(win[14]) + win[9] + sig0(win[1]) + win[0];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idx  <= '0;
      done <= 1'b0;
    end else begin
      done <= last && !abort;
      if (abort || load) idx <= '0;
      else if (xfer)     idx <= idx + 6'd1;
    end
  end

  assign w_out   = win[0];
  assign w_index = idx;

endmodule

// File: tb/tb_sha256_w_sched_ctrl.sv
// Scoreboard bench for sha256_w_sched_ctrl: expected schedule words are queued at
// start; a negedge monitor pops and compares every accepted word.
module tb_sha256_w_sched_ctrl;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [511:0] block_in = '0;
  logic         w_ready = 1'b1;
  logic         w_valid;
  logic [31:0]  w_out;
  logic [5:0]   w_index;
  logic         busy;
  logic         done;

  int           n_cmp = 0;
  int           n_bad = 0;
  int           done_cnt = 0;
  bit           rand_mode = 1'b0;
  logic [37:0]  sbq [$];

  logic [511:0] blk_abc, blk2, blk3;

  sha256_w_sched_ctrl dut (
    .CLK(CLK), .RST(RST), .start(start), .abort(abort), .block_in(block_in),
    .w_ready(w_ready), .w_valid(w_valid), .w_out(w_out), .w_index(w_index),
    .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference schedule computed over a flat 64-entry array
  task automatic push_block(input logic [511:0] b);
    logic [31:0] w [64];
    logic [31:0] a, c;
    for (int t = 0; t < 16; t++) w[t] = b[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      a = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
      c = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
      w[t] = a + w[t-7] + c + w[t-16];
    end
    for (int t = 0; t < 64; t++) sbq.push_back({6'(t), w[t]});
  endtask

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      w_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    logic        stall_prev = 1'b0;
    logic [31:0] held_out = '0;
    logic [5:0]  held_idx = '0;
    logic [37:0] e;
    forever begin
      @(negedge CLK);
      if (done) done_cnt++;
      if (stall_prev && w_valid) begin
        chk("hold_out", w_out, held_out);
        chk("hold_idx", w_index, held_idx);
      end
      stall_prev = w_valid && !w_ready;
      held_out   = w_out;
      held_idx   = w_index;
      if (w_valid && w_ready) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word: got idx %0d val %0h expected none", w_index, w_out);
        end else begin
          e = sbq.pop_front();
          chk("word_idx", w_index, e[37:32]);
          chk("word_val", w_out, e[31:0]);
        end
      end
    end
  end

  task automatic start_block(input logic [511:0] b, output int cnt);
    block_in = b;
    push_block(b);
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    cnt = 1;
    chk("first_valid", w_valid, 1);
    chk("first_idx", w_index, 0);
  endtask

  task automatic wait_done(input int cnt0, input bit timing, input bit inject, input bit abc);
    int cnt = cnt0;
    while (!done && cnt < 1000) begin
      if (abc && cnt == 17) chk("abc_w16", w_out, 32'h61626380);
      if (abc && cnt == 18) chk("abc_w17", w_out, 32'h000F0000);
      start = inject && busy && (w_index == 6'd10 || w_index == 6'd40);
      @(posedge CLK); #1;
      cnt++;
    end
    start = 1'b0;
    chk("done_seen", done, 1);
    chk("busy_at_done", busy, 0);
    if (timing) chk("done_cycle", cnt, 65);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_valid"}, w_valid, 0);
    chk({nm, "_out"}, w_out, 0);
    chk({nm, "_idx"}, w_index, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
  endtask

  initial begin
    int cnt;
    int dc;
    blk_abc = {32'h61626380, 448'h0, 32'h00000018};
    for (int i = 0; i < 16; i++) begin
      blk2[511 - 32*i -: 32] = 32'h9E3779B9 * (i + 1);
      blk3[511 - 32*i -: 32] = 32'hA5A5_0000 ^ (32'h0101_0101 << i);
    end

    repeat (3) @(posedge CLK);
    #1;
    check_zero("reset");
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;

    // abc block, ready held high
    dc = done_cnt;
    start_block(blk_abc, cnt);
    wait_done(cnt, 1'b1, 1'b0, 1'b1);
    @(posedge CLK); #1;
    chk("abc_done_count", done_cnt, dc + 1);

    // abc block, ready toggled
    rand_mode = 1'b1;
    start_block(blk_abc, cnt);
    wait_done(cnt, 1'b0, 1'b0, 1'b0);
    rand_mode = 1'b0;
    repeat (2) @(posedge CLK);
    #1;

    // back-to-back: second start in the done cycle
    start_block(blk2, cnt);
    wait_done(cnt, 1'b1, 1'b0, 1'b0);
    start_block(blk3, cnt);
    chk("b2b_w0", w_out, blk3[511:480]);
    wait_done(cnt, 1'b1, 1'b0, 1'b0);
    @(posedge CLK); #1;

    // start pulses mid-block are ignored
    dc = done_cnt;
    start_block(blk_abc, cnt);
    wait_done(cnt, 1'b1, 1'b1, 1'b1);
    repeat (3) @(posedge CLK);
    #1;
    chk("inject_done_count", done_cnt, dc + 1);

    // abort at index 20
    dc = done_cnt;
    start_block(blk2, cnt);
    while (w_index != 6'd20 && cnt < 100) begin
      @(posedge CLK); #1;
      cnt++;
    end
    chk("abort_reach_20", w_index, 20);
    abort = 1'b1;
    @(posedge CLK); #1;
    abort = 1'b0;
    chk("abort_valid", w_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_idx", w_index, 0);
    sbq.delete();
    repeat (3) @(posedge CLK);
    #1;
    chk("abort_no_done", done_cnt, dc);
    abort = 1'b1;
    start = 1'b1;
    block_in = blk3;
    @(posedge CLK); #1;
    abort = 1'b0;
    start = 1'b0;
    chk("abort_start_drop", busy, 0);
    start_block(blk3, cnt);
    wait_done(cnt, 1'b1, 1'b0, 1'b0);
    @(posedge CLK); #1;

    // asynchronous reset mid-block
    start_block(blk2, cnt);
    while (w_index != 6'd30 && cnt < 100) begin
      @(posedge CLK); #1;
      cnt++;
    end
    #2;
    RST = 1'b1;
    #1;
    check_zero("async_rst");
    sbq.delete();
    @(posedge CLK);
    #3;
    RST = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    chk("post_rst_valid", w_valid, 0);
    chk("post_rst_busy", busy, 0);
    start_block(blk_abc, cnt);
    wait_done(cnt, 1'b1, 1'b0, 1'b1);

    repeat (3) @(posedge CLK);
    #1;
    chk("queue_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
